// File: rtl/fft_pkg.sv
// Shared definitions for the FFT memory controller: controller state
// encoding, default build constants and the index arithmetic used to walk an
// in-place radix-2 DIT transform.
package fft_pkg;

    localparam int unsigned FFT_LOG2N_DEF  = 4;
    localparam int unsigned FFT_ADDR_W_DEF = 16;
    localparam int unsigned FFT_WB_LAT_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD,
        DONE
    } fft_state_t;

    // Reverse the low nbits of v; bits above nbits come back as zero.
    function automatic logic [31:0] fft_bitrev(input logic [31:0] v,
                                               input int unsigned nbits);
        logic [31:0] r;
        logic [31:0] x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], x[0]};
                x = x >> 1;
            end
        end
        return r;
    endfunction

    // Upper-wing address of butterfly k in stage s.
    function automatic int unsigned fft_bfly_a(input int unsigned s,
                                               input int unsigned k);
        int unsigned half;
        half = 1 << s;
        return ((k >> s) << (s + 1)) | (k & (half - 1));
    endfunction

    // Lower-wing address of butterfly k in stage s.
    function automatic int unsigned fft_bfly_b(input int unsigned s,
                                               input int unsigned k);
        return fft_bfly_a(s, k) + (1 << s);
    endfunction

    // Twiddle ROM index of butterfly k in stage s of a 2**log2n transform.
    function automatic int unsigned fft_bfly_tw(input int unsigned s,
                                                input int unsigned k,
                                                input int unsigned log2n);
        int unsigned half;
        half = 1 << s;
        return (k & (half - 1)) << (log2n - 1 - s);
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Writeback delay line: carries each compute read's {address, valid} forward
// so the butterfly result is written back to the same address DEPTH cycles
// after it was loaded into the slot.
//   clk       system clock
//   rst       synchronous active-high clear of every slot
//   in_addr   address entering the line
//   in_valid  marks a real read (as opposed to an idle cycle)
//   out_addr  address leaving the line after DEPTH clocks
//   out_valid valid leaving the line after DEPTH clocks
module fft_wb_delay #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] in_addr,
    input  logic          in_valid,
    output logic [AW-1:0] out_addr,
    output logic          out_valid
);

    logic [DEPTH-1:0][AW-1:0] addr_sr;
    logic [DEPTH-1:0]         valid_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_sr  <= '0;
            valid_sr <= '0;
        end else begin
            addr_sr  <= {addr_sr[DEPTH-2:0], in_addr};
            valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
        end
    end

    assign out_addr  = addr_sr[DEPTH-1];
    assign out_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/fft_mem_ctrl.sv
// Address/control sequencer for one in-place radix-2 DIT FFT held in a
// dual-port RAM (write on posedge, read on negedge). Loads N samples in
// bit-reversed order, walks LOG2N butterfly stages, then streams the result
// out in natural order.
//   clk, rst     system clock, synchronous active-high reset
//   start        begin a transform (IDLE only)
//   in_valid     sample present on RAM data_in (LOAD only)
//   write_addr   RAM write address     write_en  RAM write enable
//   read_addr    RAM read address
//   bfly_ld_a/b  butterfly captures RAM data_out as operand A/B
//   twiddle_idx  twiddle ROM index, valid with bfly_ld_a
//   stage        current compute stage
//   out_valid    RAM data_out is an output sample
//   busy         not IDLE              done  one-cycle completion pulse
module fft_mem_ctrl
    import fft_pkg::*;
#(
    parameter  int unsigned LOG2N          = FFT_LOG2N_DEF,
    parameter  int unsigned ADDR_BIT_WIDTH = FFT_ADDR_W_DEF,
    parameter  int unsigned WB_LAT         = FFT_WB_LAT_DEF,
    localparam int unsigned TW_W = (LOG2N > 1) ? LOG2N - 1 : 1,
    localparam int unsigned ST_W = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic [ADDR_BIT_WIDTH-1:0] write_addr,
    output logic                      write_en,
    output logic [ADDR_BIT_WIDTH-1:0] read_addr,
    output logic                      bfly_ld_a,
    output logic                      bfly_ld_b,
    output logic [TW_W-1:0]           twiddle_idx,
    output logic [ST_W-1:0]           stage,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned N         = 1 << LOG2N;
    localparam int unsigned STAGE_CYC = N + WB_LAT;
    localparam int unsigned CW        = $clog2(STAGE_CYC) + 1;

    fft_state_t state_q, state_n;
    logic [CW-1:0]             cnt_q, cnt_n, k_n;
    logic [ST_W-1:0]           stage_q, stage_n;
    logic [ADDR_BIT_WIDTH-1:0] rd_addr_n, wr_addr_n, wb_addr;
    logic [TW_W-1:0]           tw_n;
    logic                      rd_v_n, ld_a_n, ld_b_n, out_valid_n;
    logic                      wr_en_n, wb_valid;

    // Next-state logic. cnt is the load count in LOAD, the cycle within the
    // stage in COMPUTE (reads in 0..N-1, last writeback at N+WB_LAT-1) and
    // the read index in UNLOAD.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        stage_n = stage_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_n = COMPUTE;
                        cnt_n   = '0;
                        stage_n = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == CW'(STAGE_CYC - 1)) begin
                    cnt_n = '0;
                    if (stage_q == ST_W'(LOG2N - 1)) begin
                        state_n = UNLOAD;
                    end else begin
                        stage_n = stage_q + ST_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            UNLOAD: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read-side outputs are decoded from the next state/counter so that the
    // registered outputs line up with the cycle the state register describes.
    always_comb begin
        rd_addr_n   = '0;
        rd_v_n      = 1'b0;
        ld_a_n      = 1'b0;
        ld_b_n      = 1'b0;
        tw_n        = '0;
        out_valid_n = 1'b0;
        k_n         = cnt_n >> 1;
        if (state_n == COMPUTE && cnt_n < CW'(N)) begin
            rd_v_n = 1'b1;
            if (cnt_n[0]) begin
                ld_b_n    = 1'b1;
                rd_addr_n = ADDR_BIT_WIDTH'(fft_bfly_b(32'(stage_n), 32'(k_n)));
            end else begin
                ld_a_n    = 1'b1;
                rd_addr_n = ADDR_BIT_WIDTH'(fft_bfly_a(32'(stage_n), 32'(k_n)));
                tw_n      = TW_W'(fft_bfly_tw(32'(stage_n), 32'(k_n), LOG2N));
            end
        end else if (state_n == UNLOAD) begin
            out_valid_n = 1'b1;
            rd_addr_n   = ADDR_BIT_WIDTH'(cnt_n);
        end
    end

    // The line is fed the value about to be registered onto read_addr, so
    // its last slot plus the write_addr register give exactly WB_LAT cycles.
    fft_wb_delay #(
        .DEPTH (WB_LAT),
        .AW    (ADDR_BIT_WIDTH)
    ) u_wb_delay (
        .clk       (clk),
        .rst       (rst),
        .in_addr   (rd_addr_n),
        .in_valid  (rd_v_n),
        .out_addr  (wb_addr),
        .out_valid (wb_valid)
    );

    // Load writes and compute writebacks never coincide: the line is empty
    // throughout LOAD and only starts emitting WB_LAT cycles into COMPUTE.
    always_comb begin
        wr_en_n   = 1'b0;
        wr_addr_n = '0;
        if (state_q == LOAD && in_valid) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ADDR_BIT_WIDTH'(fft_bitrev(32'(cnt_q), LOG2N));
        end else if (wb_valid) begin
            wr_en_n   = 1'b1;
            wr_addr_n = wb_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            write_addr  <= '0;
            write_en    <= 1'b0;
            read_addr   <= '0;
            bfly_ld_a   <= 1'b0;
            bfly_ld_b   <= 1'b0;
            twiddle_idx <= '0;
            stage       <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            stage_q     <= stage_n;
            write_addr  <= wr_addr_n;
            write_en    <= wr_en_n;
            read_addr   <= rd_addr_n;
            bfly_ld_a   <= ld_a_n;
            bfly_ld_b   <= ld_b_n;
            twiddle_idx <= tw_n;
            stage       <= (state_n == COMPUTE) ? stage_n : '0;
            out_valid   <= out_valid_n;
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Scoreboard bench for fft_mem_ctrl: an N=16 instance and an N=2 instance.
// The driver pushes cycle-stamped expected events computed from the FFT
// index rules; a negedge monitor pops and compares whatever the DUTs emit.
module tb_fft_mem_ctrl;

    localparam int WB = 3;
    localparam int KA = 4;  // {ld_a, ld_b, out_valid} = 100
    localparam int KB = 2;
    localparam int KO = 1;

    typedef struct {
        int inst;
        int cyc;
        int kind;
        int addr;
        int tw;
        int stg;
    } ev_t;

    ev_t exp_wr[$];
    ev_t exp_rd[$];
    ev_t exp_dn[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic clk = 1'b0;
    logic rst_v[2];
    logic start_v[2];
    logic in_valid_v[2];

    logic [15:0] wa0, ra0, wa1, ra1;
    logic        we0, la0, lb0, ov0, busy0, done0;
    logic        we1, la1, lb1, ov1, busy1, done1;
    logic [2:0]  tw0;
    logic [1:0]  st0;
    logic [0:0]  tw1, st1;

    fft_mem_ctrl #(.LOG2N(4), .ADDR_BIT_WIDTH(16), .WB_LAT(WB)) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .write_addr(wa0), .write_en(we0), .read_addr(ra0),
        .bfly_ld_a(la0), .bfly_ld_b(lb0), .twiddle_idx(tw0), .stage(st0),
        .out_valid(ov0), .busy(busy0), .done(done0)
    );

    fft_mem_ctrl #(.LOG2N(1), .ADDR_BIT_WIDTH(16), .WB_LAT(WB)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .write_addr(wa1), .write_en(we1), .read_addr(ra1),
        .bfly_ld_a(la1), .bfly_ld_b(lb1), .twiddle_idx(tw1), .stage(st1),
        .out_valid(ov1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, want finish (bad=%0d)", bad);
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm, input int inst);
        total++;
        bad++;
        $display("FAIL %s: got event on dut%0d at cycle %0d, want none", nm, inst, cyc);
    endtask

    function automatic ev_t mk(input int inst, input int c, input int kind,
                               input int addr, input int tw, input int stg);
        ev_t e;
        e.inst = inst; e.cyc = c; e.kind = kind;
        e.addr = addr; e.tw = tw; e.stg = stg;
        return e;
    endfunction

    function automatic int ref_bitrev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic mon(input int inst, input logic we, input int wa,
                       input logic la, input logic lb, input logic ov,
                       input int ra, input int tw, input int st, input logic dn);
        ev_t e;
        if (we) begin
            if (exp_wr.size() == 0) unexpected("write", inst);
            else begin
                e = exp_wr.pop_front();
                check("write dut", inst, e.inst);
                check("write cycle", cyc, e.cyc);
                check("write addr", wa, e.addr);
            end
        end
        if (la || lb || ov) begin
            if (exp_rd.size() == 0) unexpected("read", inst);
            else begin
                e = exp_rd.pop_front();
                check("read dut", inst, e.inst);
                check("read cycle", cyc, e.cyc);
                check("read kind", int'({la, lb, ov}), e.kind);
                check("read addr", ra, e.addr);
                if (e.kind == KA) check("twiddle", tw, e.tw);
                if (e.kind != KO) check("stage", st, e.stg);
            end
        end
        if (dn) begin
            if (exp_dn.size() == 0) unexpected("done", inst);
            else begin
                e = exp_dn.pop_front();
                check("done dut", inst, e.inst);
                check("done cycle", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, we0, int'(wa0), la0, lb0, ov0, int'(ra0), int'(tw0), int'(st0), done0);
            mon(1, we1, int'(wa1), la1, lb1, ov1, int'(ra1), int'(tw1), int'(st1), done1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Butterflies enumerated group by group: each group spans 2*half
    // addresses and pairs j with j+half, using every (N/(2*half))-th twiddle.
    task automatic push_schedule(input int inst, input int lg, input int c0);
        int n, per, half, idx, t, u0;
        n   = 1 << lg;
        per = n + WB;
        for (int s = 0; s < lg; s++) begin
            half = 1 << s;
            idx  = 0;
            for (int g = 0; g < n; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    t = c0 + s * per + 2 * idx;
                    exp_rd.push_back(mk(inst, t,     KA, g + j,        j * (n / (2 * half)), s));
                    exp_rd.push_back(mk(inst, t + 1, KB, g + j + half, 0, s));
                    exp_wr.push_back(mk(inst, t + WB,     0, g + j,        0, 0));
                    exp_wr.push_back(mk(inst, t + 1 + WB, 0, g + j + half, 0, 0));
                    idx++;
                end
            end
        end
        u0 = c0 + lg * per;
        for (int i = 0; i < n; i++) exp_rd.push_back(mk(inst, u0 + i, KO, i, 0, 0));
        exp_dn.push_back(mk(inst, u0 + n, 0, 0, 0, 0));
    endtask

    function automatic int outs_ones(input int inst);
        if (inst == 0)
            return $countones({wa0, we0, ra0, la0, lb0, tw0, st0, ov0, busy0, done0});
        return $countones({wa1, we1, ra1, la1, lb1, tw1, st1, ov1, busy1, done1});
    endfunction

    // mode 0: back-to-back samples; 1: every other cycle; 2: random gaps plus
    // stray start/in_valid during COMPUTE and UNLOAD. do_rst aborts mid-stage 2.
    task automatic run_transform(input int inst, input int mode, input bit do_rst);
        int lg, n, acc, c0, u0, r, ph;
        bit v;
        lg  = (inst == 0) ? 4 : 1;
        n   = 1 << lg;
        acc = 0;
        c0  = 0;
        ph  = 0;
        start_v[inst] = 1'b1;
        next_cycle();
        start_v[inst] = 1'b0;
        while (acc < n) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (ph % 2 == 0);
                default: v = ($urandom % 3) != 0;
            endcase
            ph++;
            in_valid_v[inst] = v;
            if (mode == 2) start_v[inst] = 1'($urandom % 2);
            if (v) begin
                exp_wr.push_back(mk(inst, cyc + 1, 0, ref_bitrev(acc, lg), 0, 0));
                acc++;
                if (acc == n) c0 = cyc + 1;
            end
            next_cycle();
        end
        in_valid_v[inst] = 1'b0;
        start_v[inst]    = 1'b0;
        push_schedule(inst, lg, c0);
        u0 = c0 + lg * (n + WB);
        r  = c0 + 2 * (n + WB) + 5;
        while (cyc < u0 + n) begin
            if (mode == 2) begin
                start_v[inst]    = 1'($urandom % 2);
                in_valid_v[inst] = 1'($urandom % 2);
            end
            if (do_rst && cyc == r) begin
                start_v[inst]    = 1'b0;
                in_valid_v[inst] = 1'b0;
                rst_v[inst]      = 1'b1;
                while (exp_wr.size() > 0 && exp_wr[exp_wr.size()-1].cyc > r) exp_wr.delete(exp_wr.size()-1);
                while (exp_rd.size() > 0 && exp_rd[exp_rd.size()-1].cyc > r) exp_rd.delete(exp_rd.size()-1);
                while (exp_dn.size() > 0 && exp_dn[exp_dn.size()-1].cyc > r) exp_dn.delete(exp_dn.size()-1);
                next_cycle();
                rst_v[inst] = 1'b0;
                @(negedge clk);
                check("outputs after mid-run reset (ones)", outs_ones(inst), 0);
                return;
            end
            next_cycle();
        end
        start_v[inst]    = 1'b0;
        in_valid_v[inst] = 1'b0;
        next_cycle();
        @(negedge clk);
        check("busy after done", (inst == 0) ? int'(busy0) : int'(busy1), 0);
        check("events left over", exp_wr.size() + exp_rd.size() + exp_dn.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i]      = 1'b1;
            start_v[i]    = 1'b0;
            in_valid_v[i] = 1'b0;
        end
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset outputs dut0 (ones)", outs_ones(0), 0);
        check("reset outputs dut1 (ones)", outs_ones(1), 0);
        mon_en   = 1'b1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        next_cycle();

        run_transform(0, 0, 1'b0);
        run_transform(0, 1, 1'b0);
        run_transform(0, 2, 1'b0);
        run_transform(0, 0, 1'b1);
        run_transform(0, 2, 1'b0);
        run_transform(1, 0, 1'b0);
        run_transform(1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
